// File: rtl/lcd_nibble_rx.sv
// LCD bus receiver: samples an HD44780-style 4/8-bit write bus that is asynchronous
// to CLK, assembles bytes, and executes a subset of the commands.
// Data bytes land in a 32-entry character buffer (two lines of 16).
//
// state | meaning
// M8    | 8-bit mode; each nibble forms the byte {din,4'h0}
// HI    | 4-bit mode; waiting for the high nibble
// LO    | 4-bit mode; high nibble held, waiting for the low nibble
module lcd_nibble_rx (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RS,
  input  logic       E,
  input  logic [3:0] din,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_stb,
  output logic       byte_rs,
  output logic [7:0] byte_data,
  output logic [4:0] cursor,
  output logic       mode4,
  output logic       disp_on,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {ST_M8, ST_HI, ST_LO} asm_t;

  logic       rs_s1_q, rs_s2_q;
  logic       e_s1_q, e_s2_q, e_s3_q;
  logic [3:0] din_s1_q, din_s2_q;

  asm_t       asm_q, asm_d;
  logic [3:0] hi_q, hi_d;
  logic       stb_q, stb_d;
  logic       brs_q, brs_d;
  logic [7:0] bdata_q, bdata_d;
  logic [4:0] cursor_q, cursor_d;
  logic       disp_q, disp_d;
  logic       inc_q, inc_d;
  logic       busy_q, busy_d;
  logic [4:0] clr_cnt_q, clr_cnt_d;
  logic       ovr_q, ovr_d;
  logic [7:0] rd_data_q;

  logic       e_fall;
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_q [32];

  // Bring the asynchronous bus into the CLK domain; E gets one extra stage for edge detect.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rs_s1_q  <= 1'b0;
      rs_s2_q  <= 1'b0;
      e_s1_q   <= 1'b0;
      e_s2_q   <= 1'b0;
      e_s3_q   <= 1'b0;
      din_s1_q <= 4'h0;
      din_s2_q <= 4'h0;
    end else begin
      rs_s1_q  <= RS;
      rs_s2_q  <= rs_s1_q;
      e_s1_q   <= E;
      e_s2_q   <= e_s1_q;
      e_s3_q   <= e_s2_q;
      din_s1_q <= din;
      din_s2_q <= din_s1_q;
    end
  end

  assign e_fall = e_s3_q & ~e_s2_q;

  // Assembler FSM, clear sequencer, and command/data execution for the registered byte.
  always_comb begin
    asm_d     = asm_q;
    hi_d      = hi_q;
    stb_d     = 1'b0;
    brs_d     = brs_q;
    bdata_d   = bdata_q;
    cursor_d  = cursor_q;
    disp_d    = disp_q;
    inc_d     = inc_q;
    busy_d    = busy_q;
    clr_cnt_d = clr_cnt_q;
    ovr_d     = ovr_q;
    mem_we    = 1'b0;
    mem_waddr = cursor_q;
    mem_wdata = bdata_q;

    if (e_fall) begin
      case (asm_q)
        ST_M8: begin
          stb_d   = 1'b1;
          brs_d   = rs_s2_q;
          bdata_d = {din_s2_q, 4'h0};
        end
        ST_HI: begin
          hi_d  = din_s2_q;
          asm_d = ST_LO;
        end
        ST_LO: begin
          stb_d   = 1'b1;
          brs_d   = rs_s2_q;
          bdata_d = {hi_q, din_s2_q};
          asm_d   = ST_HI;
        end
        default: asm_d = ST_M8;
      endcase
    end

    // Clear walks indices 0..31 while the down-counter runs 31..0.
    if (busy_q) begin
      mem_we    = 1'b1;
      mem_waddr = ~clr_cnt_q;
      mem_wdata = 8'h20;
      if (clr_cnt_q == 5'd0) begin
        busy_d   = 1'b0;
        cursor_d = 5'd0;
        inc_d    = 1'b1;
      end else begin
        clr_cnt_d = clr_cnt_q - 5'd1;
      end
    end

    // A completed byte is executed in the cycle it is presented on byte_stb.
    if (stb_q) begin
      if (busy_q) begin
        ovr_d = 1'b1;
      end else if (brs_q) begin
        mem_we    = 1'b1;
        mem_waddr = cursor_q;
        mem_wdata = bdata_q;
        cursor_d  = inc_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
      end else begin
        casez (bdata_q)
          8'b1???????: cursor_d = {bdata_q[6], bdata_q[3:0]};
          8'b01??????: ;
          8'b001?????: asm_d = bdata_q[4] ? ST_M8 : ST_HI;
          8'b0001????: ;
          8'b00001???: disp_d = bdata_q[2];
          8'b000001??: inc_d = bdata_q[1];
          8'b0000001?: cursor_d = 5'd0;
          8'b00000001: begin
            busy_d    = 1'b1;
            clr_cnt_d = 5'd31;
          end
          default: ;
        endcase
      end
    end
  end

  // Control registers; reset arms a fresh clear so the buffer starts as spaces.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      asm_q     <= ST_M8;
      hi_q      <= 4'h0;
      stb_q     <= 1'b0;
      brs_q     <= 1'b0;
      bdata_q   <= 8'h00;
      cursor_q  <= 5'd0;
      disp_q    <= 1'b0;
      inc_q     <= 1'b1;
      busy_q    <= 1'b1;
      clr_cnt_q <= 5'd31;
      ovr_q     <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      hi_q      <= hi_d;
      stb_q     <= stb_d;
      brs_q     <= brs_d;
      bdata_q   <= bdata_d;
      cursor_q  <= cursor_d;
      disp_q    <= disp_d;
      inc_q     <= inc_d;
      busy_q    <= busy_d;
      clr_cnt_q <= clr_cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  // Character buffer write port (no reset; contents come from the clear sequence).
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Registered read; a same-cycle write to the same index returns the old value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rd_data_q <= 8'h00;
    else      rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data   = rd_data_q;
  assign byte_stb  = stb_q;
  assign byte_rs   = brs_q;
  assign byte_data = bdata_q;
  assign cursor    = cursor_q;
  assign mode4     = (asm_q != ST_M8);
  assign disp_on   = disp_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// Directed bench for lcd_nibble_rx: drives the LCD bus like a slow driver and checks
// the receiver's flags, cursor and buffer against hand-computed values.
module tb_lcd_nibble_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RS = 1'b0;
  logic       E = 1'b0;
  logic [3:0] din = 4'h0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       byte_stb;
  logic       byte_rs;
  logic [7:0] byte_data;
  logic [4:0] cursor;
  logic       mode4;
  logic       disp_on;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int stb_seen = 0;
  int busy_cnt = 0;
  int busy_runs = 0;
  int last_busy_len = 0;

  lcd_nibble_rx dut (
    .CLK(CLK), .RST(RST), .RS(RS), .E(E), .din(din), .rd_addr(rd_addr),
    .rd_data(rd_data), .byte_stb(byte_stb), .byte_rs(byte_rs), .byte_data(byte_data),
    .cursor(cursor), .mode4(mode4), .disp_on(disp_on), .busy(busy), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  // Measure the length of each busy run (in cycles) outside reset.
  always @(negedge CLK) begin
    if (!RST) busy_cnt = 0;
    else if (busy) busy_cnt++;
    else if (busy_cnt != 0) begin
      last_busy_len = busy_cnt;
      busy_runs++;
      busy_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  task automatic send_nibble(input logic rs, input logic [3:0] d);
    @(negedge CLK);
    RS = rs;
    din = d;
    E = 1'b1;
    repeat (3) @(negedge CLK);
    E = 1'b0;
    stb_seen = 0;
    repeat (6) begin
      @(negedge CLK);
      if (byte_stb) stb_seen++;
    end
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    send_nibble(rs, b[7:4]);
    send_nibble(rs, b[3:0]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle busy=%0b after %0d cycles, required 0", busy, n);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic read_buf(input logic [4:0] a, output logic [7:0] v);
    @(negedge CLK);
    rd_addr = a;
    @(negedge CLK);
    v = rd_data;
  endtask

  task automatic test_reset();
    int runs0;
    logic [7:0] v;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (byte_stb !== 1'b0) begin errors++; $display("FAIL rst_byte_stb got %0b want 0", byte_stb); end
    checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL rst_byte_data got %h want 00", byte_data); end
    checks++; if (cursor !== 5'd0) begin errors++; $display("FAIL rst_cursor got %0d want 0", cursor); end
    checks++; if (mode4 !== 1'b0 || disp_on !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL rst_flags got mode4=%0b disp=%0b ovr=%0b want 0 0 0", mode4, disp_on, overrun);
    end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h want 00", rd_data); end
    runs0 = busy_runs;
    @(posedge CLK);
    #2 RST = 1'b1;
    repeat (5) @(negedge CLK);
    wait_idle();
    checks++; if (busy_runs != runs0 + 1 || last_busy_len != 32) begin
      errors++; $display("FAIL rst_clear_len got runs=%0d len=%0d want runs=%0d len=32", busy_runs - runs0, last_busy_len, 1);
    end
    for (int i = 0; i < 32; i++) begin
      read_buf(5'(i), v);
      checks++; if (v !== 8'h20) begin errors++; $display("FAIL rst_buf[%0d] got %h want 20", i, v); end
    end
    checks++; if (cursor !== 5'd0) begin errors++; $display("FAIL rst_cursor_after got %0d want 0", cursor); end
  endtask

  task automatic test_init();
    int runs0;
    for (int i = 0; i < 3; i++) begin
      send_nibble(1'b0, 4'h3);
      checks++; if (stb_seen != 1 || byte_data !== 8'h30) begin
        errors++; $display("FAIL init_nib%0d got stb=%0d data=%h want 1 30", i, stb_seen, byte_data);
      end
    end
    checks++; if (mode4 !== 1'b0) begin errors++; $display("FAIL init_mode4_early got %0b want 0", mode4); end
    send_nibble(1'b0, 4'h2);
    checks++; if (mode4 !== 1'b1 || byte_data !== 8'h20) begin
      errors++; $display("FAIL init_mode4 got mode4=%0b data=%h want 1 20", mode4, byte_data);
    end
    send_byte(1'b0, 8'h28);
    checks++; if (mode4 !== 1'b1 || byte_data !== 8'h28 || byte_rs !== 1'b0) begin
      errors++; $display("FAIL init_28 got mode4=%0b data=%h rs=%0b want 1 28 0", mode4, byte_data, byte_rs);
    end
    send_byte(1'b0, 8'h0C);
    checks++; if (disp_on !== 1'b1) begin errors++; $display("FAIL init_disp_on got %0b want 1", disp_on); end
    send_byte(1'b0, 8'h06);
    runs0 = busy_runs;
    send_byte(1'b0, 8'h01);
    wait_idle();
    checks++; if (busy_runs != runs0 + 1 || last_busy_len != 32) begin
      errors++; $display("FAIL init_clear_len got runs=%0d len=%0d want runs=1 len=32", busy_runs - runs0, last_busy_len);
    end
    checks++; if (cursor !== 5'd0) begin errors++; $display("FAIL init_cursor got %0d want 0", cursor); end
  endtask

  task automatic test_data();
    logic [7:0] v;
    send_byte(1'b0, 8'hC5);
    checks++; if (cursor !== 5'd21) begin errors++; $display("FAIL data_cursor_set got %0d want 21", cursor); end
    send_byte(1'b1, 8'h54);
    send_byte(1'b1, 8'h68);
    checks++; if (byte_rs !== 1'b1 || byte_data !== 8'h68) begin
      errors++; $display("FAIL data_last_byte got rs=%0b data=%h want 1 68", byte_rs, byte_data);
    end
    read_buf(5'd21, v);
    checks++; if (v !== 8'h54) begin errors++; $display("FAIL data_buf21 got %h want 54", v); end
    read_buf(5'd22, v);
    checks++; if (v !== 8'h68) begin errors++; $display("FAIL data_buf22 got %h want 68", v); end
    checks++; if (cursor !== 5'd23) begin errors++; $display("FAIL data_cursor got %0d want 23", cursor); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    send_byte(1'b0, 8'h04);
    send_byte(1'b0, 8'h80);
    checks++; if (cursor !== 5'd0) begin errors++; $display("FAIL wrap_cursor_set got %0d want 0", cursor); end
    send_byte(1'b1, 8'h41);
    read_buf(5'd0, v);
    checks++; if (v !== 8'h41) begin errors++; $display("FAIL wrap_buf0 got %h want 41", v); end
    checks++; if (cursor !== 5'd31) begin errors++; $display("FAIL wrap_down got %0d want 31", cursor); end
    send_byte(1'b0, 8'h06);
    send_byte(1'b1, 8'h42);
    checks++; if (cursor !== 5'd0) begin errors++; $display("FAIL wrap_up got %0d want 0", cursor); end
    read_buf(5'd31, v);
    checks++; if (v !== 8'h42) begin errors++; $display("FAIL wrap_buf31 got %h want 42", v); end
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial got %0b want 0", overrun); end
    send_byte(1'b0, 8'h01);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovr_busy_start got %0b want 1", busy); end
    send_nibble(1'b1, 4'h4);
    send_nibble(1'b1, 4'h1);
    checks++; if (stb_seen != 1 || byte_data !== 8'h41) begin
      errors++; $display("FAIL ovr_stb got stb=%0d data=%h want 1 41", stb_seen, byte_data);
    end
    checks++; if (overrun !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL ovr_flag got ovr=%0b busy=%0b want 1 1", overrun, busy);
    end
    wait_idle();
    for (int i = 0; i < 32; i++) begin
      read_buf(5'(i), v);
      checks++; if (v !== 8'h20) begin errors++; $display("FAIL ovr_buf[%0d] got %h want 20", i, v); end
    end
    checks++; if (cursor !== 5'd0 || overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_after got cursor=%0d ovr=%0b want 0 1", cursor, overrun);
    end
  endtask

  task automatic test_reset_lo();
    logic [7:0] v;
    send_nibble(1'b1, 4'h4);
    checks++; if (stb_seen != 0 || mode4 !== 1'b1) begin
      errors++; $display("FAIL rlo_hi_nibble got stb=%0d mode4=%0b want 0 1", stb_seen, mode4);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++; if (mode4 !== 1'b0 || overrun !== 1'b0 || byte_data !== 8'h00 || cursor !== 5'd0) begin
      errors++; $display("FAIL rlo_async got mode4=%0b ovr=%0b data=%h cursor=%0d want 0 0 00 0", mode4, overrun, byte_data, cursor);
    end
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    repeat (3) @(negedge CLK);
    wait_idle();
    send_nibble(1'b1, 4'h5);
    checks++; if (stb_seen != 1 || byte_data !== 8'h50 || byte_rs !== 1'b1) begin
      errors++; $display("FAIL rlo_m8_byte got stb=%0d data=%h rs=%0b want 1 50 1", stb_seen, byte_data, byte_rs);
    end
    checks++; if (mode4 !== 1'b0 || cursor !== 5'd1) begin
      errors++; $display("FAIL rlo_state got mode4=%0b cursor=%0d want 0 1", mode4, cursor);
    end
    read_buf(5'd0, v);
    checks++; if (v !== 8'h50) begin errors++; $display("FAIL rlo_buf0 got %h want 50", v); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_data();
    test_wrap();
    test_overrun();
    test_reset_lo();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
